pkt_capt: RTL and testbench

Capture front end between the Ethernet MAC's Avalon-ST receive port and the packet FIFO that feeds `wr_ctrl`. Admits at most one packet at a time into the FIFO, counts its length in bytes, truncates oversize frames, and latches the arrival timestamp. Once the packet is fully in the FIFO, it issues the one-cycle `wr_ctrl` start pulse with `pkt_begin`/`pkt_end`. Packets arriving while a previous one is still being drained are dropped whole and counted.

---
 rtl/pkt_capt.sv | 206 ++++++++++++++++++++
 tb/tb_pkt_capt.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_capt.sv
// pkt_capt: admits one Avalon-ST packet at a time into the packet FIFO and starts wr_ctrl.
// Define PKT_CAPT_SNAPLEN_EN to truncate captures at SNAPLEN bytes instead of MAX_PKT_BYTES.
module pkt_capt #(
   parameter int MAX_PKT_BYTES = 2048,
   parameter int SNAPLEN       = 96
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] st_data,
   input  logic        st_valid,
   input  logic        st_sop,
   input  logic        st_eop,
   input  logic [1:0]  st_empty,
   output logic        st_ready,
   output logic [31:0] fifo_data,
   output logic        fifo_wrreq,
   input  logic [8:0]  usedw,
   output logic        wr_ctrl,
   output logic [31:0] pkt_begin,
   output logic [31:0] pkt_end,
   input  logic        wr_ctrl_rdy,
   input  logic [31:0] seconds,
   input  logic [31:0] nanoseconds,
   output logic [31:0] ts_sec,
   output logic [31:0] ts_nsec,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count,
   output logic [31:0] trunc_count
);

`ifdef PKT_CAPT_SNAPLEN_EN
   localparam bit SNAP_ON = 1'b1;
`else
   localparam bit SNAP_ON = 1'b0;
`endif
   localparam int          LIMIT = SNAP_ON ? SNAPLEN : MAX_PKT_BYTES;
   localparam logic [31:0] LIM   = 32'(LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      CAPT,
      DISCARD,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t      state, state_n;
   logic [31:0] byte_cnt, byte_cnt_n;
   logic        pend, pend_n;
   logic        disc, disc_n;
   logic [2:0]  wb_cnt, wb_cnt_n;
   logic        wr_en, admit, drop, trunc, issue;

   // One input register stage decouples the MAC timing from the FSM.
   logic        in_valid, in_sop, in_eop, in_en;
   logic [1:0]  in_empty;
   logic [31:0] in_data, in_sec, in_nsec;
   logic        sop_beat;

   assign sop_beat  = in_valid && in_sop;
   assign pkt_begin = '0;

   always_comb begin
      state_n    = state;
      byte_cnt_n = byte_cnt;
      pend_n     = pend;
      disc_n     = disc;
      wb_cnt_n   = wb_cnt;
      wr_en      = 1'b0;
      admit      = 1'b0;
      drop       = 1'b0;
      trunc      = 1'b0;
      issue      = 1'b0;
      unique case (state)
         IDLE: begin
            if (sop_beat) begin
               pend_n = 1'b0;
               if (in_en && wr_ctrl_rdy && usedw == '0) begin
                  admit = 1'b1;
                  wr_en = 1'b1;
                  if (in_eop) begin
                     byte_cnt_n = 32'd4 - 32'(in_empty);
                     state_n    = ISSUE;
                  end else if (32'd4 >= LIM) begin
                     byte_cnt_n = LIM;
                     trunc      = 1'b1;
                     pend_n     = 1'b1;
                     state_n    = DISCARD;
                  end else begin
                     byte_cnt_n = 32'd4;
                     state_n    = CAPT;
                  end
               end else begin
                  drop = 1'b1;
                  if (!in_eop) state_n = DISCARD;
               end
            end
         end
         CAPT: begin
            if (sop_beat) begin
               // Missing EOP: commit what we have and drop the newcomer.
               drop = 1'b1;
               if (in_eop) begin
                  state_n = ISSUE;
               end else begin
                  pend_n  = 1'b1;
                  state_n = DISCARD;
               end
            end else if (in_valid) begin
               wr_en = 1'b1;
               if (in_eop) begin
                  byte_cnt_n = byte_cnt + 32'd4 - 32'(in_empty);
                  state_n    = ISSUE;
               end else if (byte_cnt + 32'd4 >= LIM) begin
                  byte_cnt_n = LIM;
                  trunc      = 1'b1;
                  pend_n     = 1'b1;
                  state_n    = DISCARD;
               end else begin
                  byte_cnt_n = byte_cnt + 32'd4;
               end
            end
         end
         DISCARD: begin
            if (in_valid && in_eop) state_n = pend ? ISSUE : IDLE;
         end
         ISSUE: begin
            issue    = 1'b1;
            wb_cnt_n = '0;
            state_n  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!wr_ctrl_rdy || wb_cnt == 3'd3) state_n = WAIT_DONE;
            else wb_cnt_n = wb_cnt + 3'd1;
         end
         WAIT_DONE: begin
            if (wr_ctrl_rdy && usedw == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (in_valid && in_eop) disc_n = 1'b0;
      if (sop_beat && (state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE)) begin
         drop   = 1'b1;
         disc_n = !in_eop;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_ready    <= 1'b0;
         in_valid    <= 1'b0;
         in_sop      <= 1'b0;
         in_eop      <= 1'b0;
         in_en       <= 1'b0;
         in_empty    <= '0;
         in_data     <= '0;
         in_sec      <= '0;
         in_nsec     <= '0;
         state       <= IDLE;
         byte_cnt    <= '0;
         pend        <= 1'b0;
         disc        <= 1'b0;
         wb_cnt      <= '0;
         fifo_wrreq  <= 1'b0;
         fifo_data   <= '0;
         wr_ctrl     <= 1'b0;
         pkt_end     <= '0;
         ts_sec      <= '0;
         ts_nsec     <= '0;
         pkt_count   <= '0;
         drop_count  <= '0;
         trunc_count <= '0;
      end else begin
         st_ready   <= 1'b1;
         in_valid   <= st_valid && st_ready;
         in_sop     <= st_sop;
         in_eop     <= st_eop;
         in_en      <= enable;
         in_empty   <= st_empty;
         in_data    <= st_data;
         in_sec     <= seconds;
         in_nsec    <= nanoseconds;
         state      <= state_n;
         byte_cnt   <= byte_cnt_n;
         pend       <= pend_n;
         disc       <= disc_n;
         wb_cnt     <= wb_cnt_n;
         fifo_wrreq <= wr_en;
         wr_ctrl    <= issue;
         if (wr_en) fifo_data <= in_data;
         if (admit) begin
            ts_sec  <= in_sec;
            ts_nsec <= in_nsec;
         end
         if (issue) begin
            pkt_end   <= byte_cnt;
            pkt_count <= pkt_count + 32'd1;
         end
         if (drop) drop_count <= drop_count + 32'd1;
         if (trunc) trunc_count <= trunc_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pkt_capt.sv
// Scoreboard bench for pkt_capt: random frames, a packet-level reference model,
// a FIFO/wr_ctrl drain model, and an independent output monitor.
module tb_pkt_capt;

`ifdef PKT_CAPT_SNAPLEN_EN
   localparam int LIM = 96;
`else
   localparam int LIM = 2048;
`endif

   typedef struct {
      int          len;
      logic [31:0] sec;
      logic [31:0] nsec;
      int          cnt;
      int          cyc;
   } exp_pkt_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] st_data = '0;
   logic        st_valid = 1'b0;
   logic        st_sop = 1'b0;
   logic        st_eop = 1'b0;
   logic [1:0]  st_empty = '0;
   logic        st_ready;
   logic [31:0] fifo_data;
   logic        fifo_wrreq;
   logic [8:0]  usedw = '0;
   logic        wr_ctrl;
   logic [31:0] pkt_begin;
   logic [31:0] pkt_end;
   logic        wr_ctrl_rdy = 1'b1;
   logic [31:0] seconds = '0;
   logic [31:0] nanoseconds = '0;
   logic [31:0] ts_sec, ts_nsec;
   logic [31:0] pkt_count, drop_count, trunc_count;

   pkt_capt dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .st_data     (st_data),
      .st_valid    (st_valid),
      .st_sop      (st_sop),
      .st_eop      (st_eop),
      .st_empty    (st_empty),
      .st_ready    (st_ready),
      .fifo_data   (fifo_data),
      .fifo_wrreq  (fifo_wrreq),
      .usedw       (usedw),
      .wr_ctrl     (wr_ctrl),
      .pkt_begin   (pkt_begin),
      .pkt_end     (pkt_end),
      .wr_ctrl_rdy (wr_ctrl_rdy),
      .seconds     (seconds),
      .nanoseconds (nanoseconds),
      .ts_sec      (ts_sec),
      .ts_nsec     (ts_nsec),
      .pkt_count   (pkt_count),
      .drop_count  (drop_count),
      .trunc_count (trunc_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_wr[$];
   exp_pkt_t    exp_pk[$];
   exp_pkt_t    pend_ent;
   bit          pend_valid = 1'b0;
   int          m_pkt = 0;
   int          m_drop = 0;
   int          m_trunc = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endfunction

   function automatic void unexp(input string nm, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s: got unexpected event (value %0h), required none", nm, act);
   endfunction

   function automatic void bound_fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: bound expired, required completion", nm);
   endfunction

   // FIFO fill and wr_ctrl drain model.
   int fill = 0;
   int dstate = 0;
   int ddly = 0;
   always @(negedge clk) begin
      if (reset) begin
         fill = 0;
         dstate = 0;
         wr_ctrl_rdy = 1'b1;
         usedw = '0;
      end else begin
         if (fifo_wrreq === 1'b1) fill++;
         case (dstate)
            0: if (wr_ctrl === 1'b1) begin
               ddly = $urandom_range(0, 7);
               dstate = 1;
            end
            1: if (ddly == 0) begin
               wr_ctrl_rdy = 1'b0;
               dstate = 2;
            end else ddly--;
            default: if (fill > 0) fill--;
               else begin
                  wr_ctrl_rdy = 1'b1;
                  dstate = 0;
               end
         endcase
         usedw = (fill > 511) ? 9'd511 : 9'(fill);
      end
   end

   // Output monitor.
   logic [31:0] mon_w;
   exp_pkt_t    mon_e;
   always @(negedge clk) begin
      if (!reset) begin
         if (fifo_wrreq === 1'b1) begin
            if (exp_wr.size() == 0) unexp("fifo_wr", fifo_data);
            else begin
               mon_w = exp_wr.pop_front();
               chk("fifo_data", fifo_data, mon_w);
            end
         end
         if (wr_ctrl === 1'b1) begin
            if (exp_pk.size() == 0) unexp("wr_ctrl", pkt_end);
            else begin
               mon_e = exp_pk.pop_front();
               chk("pkt_end", pkt_end, 32'(mon_e.len));
               chk("pkt_begin", pkt_begin, 32'd0);
               chk("ts_sec", ts_sec, mon_e.sec);
               chk("ts_nsec", ts_nsec, mon_e.nsec);
               chk("pkt_count", pkt_count, 32'(mon_e.cnt));
               chk("wr_ctrl_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end
      end
   end

   task automatic idle_cycle();
      @(negedge clk);
      #1;
      st_valid = 1'b0;
      st_sop = 1'($urandom);
      st_eop = 1'($urandom);
      st_data = $urandom;
      seconds = $urandom;
      nanoseconds = $urandom;
   endtask

   task automatic send_frame(input int len, input bit en, input bit busy, input bit term);
      int nb;
      int cap;
      bit adm;
      bit last;
      logic [31:0] w;
      exp_pkt_t e;
      nb = (len + 3) / 4;
      cap = (nb < LIM / 4) ? nb : LIM / 4;
      adm = en && !busy;
      e.len = (len < LIM) ? len : LIM;
      e.cnt = 0;
      e.cyc = 0;
      e.sec = '0;
      e.nsec = '0;
      if (adm) begin
         m_pkt++;
         if (len > LIM) m_trunc++;
         e.cnt = m_pkt;
      end else m_drop++;
      for (int i = 0; i < nb; i++) begin
         if (i > 0 && $urandom_range(0, 7) == 0) idle_cycle();
         w = $urandom;
         last = term && (i == nb - 1);
         @(negedge clk);
         #1;
         st_valid = 1'b1;
         st_data = w;
         st_sop = (i == 0);
         st_eop = last;
         st_empty = last ? 2'(nb * 4 - len) : 2'($urandom_range(0, 3));
         enable = (i == 0) ? en : 1'($urandom);
         seconds = $urandom;
         nanoseconds = $urandom;
         if (i == 0) begin
            e.sec = seconds;
            e.nsec = nanoseconds;
         end
         if (adm && i < cap) exp_wr.push_back(w);
         if (last) begin
            if (pend_valid) begin
               pend_ent.cyc = cyc + 3;
               exp_pk.push_back(pend_ent);
               pend_valid = 1'b0;
            end
            if (adm) begin
               e.cyc = cyc + 3;
               exp_pk.push_back(e);
            end
         end
      end
      if (adm && !term) begin
         pend_ent = e;
         pend_valid = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 4000) begin
         idle_cycle();
         n++;
         if (dstate == 0 && fill == 0 && wr_ctrl_rdy && exp_pk.size() == 0 && !pend_valid)
            done = 1'b1;
      end
      if (!done) bound_fail("wait_idle");
      repeat (3) idle_cycle();
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (!(wr_ctrl_rdy == 1'b0 && fill >= 4) && n < 200) begin
         idle_cycle();
         n++;
      end
      if (n >= 200) bound_fail("wait_busy");
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_pkt_count"}, pkt_count, 32'(m_pkt));
      chk({tag, "_drop_count"}, drop_count, 32'(m_drop));
      chk({tag, "_trunc_count"}, trunc_count, 32'(m_trunc));
   endtask

   task automatic reset_check();
      @(negedge clk);
      #1;
      reset = 1'b1;
      st_valid = 1'b0;
      #1;
      chk("rst_st_ready", 32'(st_ready), 32'd0);
      chk("rst_fifo_wrreq", 32'(fifo_wrreq), 32'd0);
      chk("rst_fifo_data", fifo_data, 32'd0);
      chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
      chk("rst_pkt_end", pkt_end, 32'd0);
      chk("rst_ts_sec", ts_sec, 32'd0);
      chk("rst_ts_nsec", ts_nsec, 32'd0);
      chk("rst_pkt_count", pkt_count, 32'd0);
      chk("rst_drop_count", drop_count, 32'd0);
      chk("rst_trunc_count", trunc_count, 32'd0);
      chk("rst_pending_writes", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
      exp_pk.delete();
      pend_valid = 1'b0;
      m_pkt = 0;
      m_drop = 0;
      m_trunc = 0;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("st_ready_before_edge", 32'(st_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("st_ready_after_edge", 32'(st_ready), 32'd1);
   endtask

   initial begin
      int len;
      int mode;
      bit en;
      logic [31:0] w;
      reset_check();

      send_frame(60, 1'b1, 1'b0, 1'b1);
      wait_idle();
      check_counters("basic");
      send_frame(61, 1'b1, 1'b0, 1'b1);
      wait_idle();

      send_frame(20, 1'b1, 1'b0, 1'b1);
      send_frame(32, 1'b1, 1'b1, 1'b1);
      wait_idle();
      send_frame(40, 1'b1, 1'b0, 1'b1);
      wait_busy();
      send_frame(12, 1'b1, 1'b1, 1'b1);
      wait_idle();
      send_frame(28, 1'b1, 1'b0, 1'b1);
      wait_idle();
      check_counters("drop");

      send_frame(16, 1'b0, 1'b0, 1'b1);
      wait_idle();
      for (int l = 1; l <= 4; l++) begin
         send_frame(l, 1'b1, 1'b0, 1'b1);
         wait_idle();
      end

      send_frame(LIM, 1'b1, 1'b0, 1'b1);
      wait_idle();
      send_frame(LIM + 1, 1'b1, 1'b0, 1'b1);
      wait_idle();
      send_frame(3000, 1'b1, 1'b0, 1'b1);
      wait_idle();
      check_counters("trunc");

      send_frame(20, 1'b1, 1'b0, 1'b0);
      send_frame(24, 1'b1, 1'b1, 1'b1);
      wait_idle();
      send_frame(12, 1'b1, 1'b0, 1'b0);
      send_frame(1, 1'b1, 1'b1, 1'b1);
      wait_idle();
      check_counters("no_eop");

      repeat (30) begin
         len = $urandom_range(1, 200);
         en = ($urandom_range(0, 9) != 0);
         mode = $urandom_range(0, 5);
         if (mode == 0 && en) begin
            send_frame(4 * $urandom_range(1, 12), 1'b1, 1'b0, 1'b0);
            send_frame(len, 1'b1, 1'b1, 1'b1);
         end else if (mode == 1 && en) begin
            send_frame(len, 1'b1, 1'b0, 1'b1);
            send_frame($urandom_range(1, 40), 1'b1, 1'b1, 1'b1);
         end else begin
            send_frame(len, en, 1'b0, 1'b1);
         end
         wait_idle();
      end
      check_counters("random");

      for (int i = 0; i < 3; i++) begin
         w = $urandom;
         @(negedge clk);
         #1;
         st_valid = 1'b1;
         st_data = w;
         st_sop = (i == 0);
         st_eop = 1'b0;
         enable = 1'b1;
         if (i < 2) exp_wr.push_back(w);
      end
      reset_check();
      send_frame(36, 1'b1, 1'b0, 1'b1);
      wait_idle();
      check_counters("post_reset");
      chk("final_pending_writes", 32'(exp_wr.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
